// File: rtl/fdtd_step_ctrl.sv
// Time-step sequencer for the 1-D FDTD engine: per step sweeps Hy over cells
// 0..G-2, Ez over 1..G-1, then one source injection, then one quiet cycle.
module fdtd_step_ctrl #(
  parameter int GRID_SIZE  = 200,
  parameter int ADDR_WIDTH = 10,
  parameter int STEP_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_i,
  input  logic [STEP_WIDTH-1:0] num_steps_i,
  input  logic [ADDR_WIDTH-1:0] src_idx_i,
  input  logic                  dp_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  calc_Hy_en_o,
  output logic                  calc_Ez_en_o,
  output logic                  calc_src_en_o,
  output logic [ADDR_WIDTH-1:0] cell_addr_o,
  output logic [STEP_WIDTH-1:0] step_cnt_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(GRID_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_HY   = ADDR_WIDTH'(GRID_SIZE - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC_HY,
    S_CALC_EZ,
    S_LOAD_SRC,
    S_STEP_END,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [STEP_WIDTH-1:0] step_q,  step_d;
  logic [STEP_WIDTH-1:0] n_q,     n_d;
  logic [ADDR_WIDTH-1:0] src_q,   src_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      step_q  <= '0;
      n_q     <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      step_q  <= step_d;
      n_q     <= n_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    step_d        = step_q;
    n_d           = n_q;
    src_d         = src_q;
    done_o        = 1'b0;
    calc_Hy_en_o  = 1'b0;
    calc_Ez_en_o  = 1'b0;
    calc_src_en_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          n_d    = num_steps_i;
          // Out-of-range source cells inject at the last cell.
          src_d  = (src_idx_i > LAST_CELL) ? LAST_CELL : src_idx_i;
          step_d = '0;
          addr_d = '0;
          state_d = (num_steps_i == '0) ? S_DONE : S_CALC_HY;
        end
      end

      S_CALC_HY: begin
        calc_Hy_en_o = dp_ready_i;
        if (dp_ready_i) begin
          if (addr_q == LAST_HY) begin
            addr_d  = ADDR_WIDTH'(1);
            state_d = S_CALC_EZ;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end

      S_CALC_EZ: begin
        calc_Ez_en_o = dp_ready_i;
        if (dp_ready_i) begin
          if (addr_q == LAST_CELL) begin
            addr_d  = src_q;
            state_d = S_LOAD_SRC;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end

      S_LOAD_SRC: begin
        calc_src_en_o = dp_ready_i;
        if (dp_ready_i) state_d = S_STEP_END;
      end

      S_STEP_END: begin
        // n_q is nonzero here, so n_q-1 never underflows.
        if (step_q == n_q - STEP_WIDTH'(1)) begin
          state_d = S_DONE;
        end else begin
          step_d  = step_q + STEP_WIDTH'(1);
          addr_d  = '0;
          state_d = S_CALC_HY;
        end
      end

      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign cell_addr_o = addr_q;
  assign step_cnt_o  = step_q;

endmodule

// File: tb/tb_fdtd_step_ctrl.sv
// Bench for fdtd_step_ctrl (G=8): per-run expected op timeline is built from
// the sweep rules and a per-cycle ready pattern, then compared every cycle.
module tb_fdtd_step_ctrl;
  localparam int G    = 8;
  localparam int AW   = 4;
  localparam int SW   = 16;
  localparam int MAXC = 1024;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start_i;
  logic [SW-1:0] num_steps_i;
  logic [AW-1:0] src_idx_i;
  logic          dp_ready_i;
  logic          busy_o, done_o, calc_Hy_en_o, calc_Ez_en_o, calc_src_en_o;
  logic [AW-1:0] cell_addr_o;
  logic [SW-1:0] step_cnt_o;

  fdtd_step_ctrl #(.GRID_SIZE(G), .ADDR_WIDTH(AW), .STEP_WIDTH(SW)) dut (
    .CLK(CLK), .RST(RST), .start_i(start_i), .num_steps_i(num_steps_i),
    .src_idx_i(src_idx_i), .dp_ready_i(dp_ready_i), .busy_o(busy_o),
    .done_o(done_o), .calc_Hy_en_o(calc_Hy_en_o), .calc_Ez_en_o(calc_Ez_en_o),
    .calc_src_en_o(calc_src_en_o), .cell_addr_o(cell_addr_o), .step_cnt_o(step_cnt_o)
  );

  always #5 CLK = ~CLK;

  int vecs  = 0;
  int fails = 0;

  // Expected timeline: kind 0 quiet, 1 Hy, 2 Ez, 3 src, 4 stalled (addr held).
  bit rdy      [MAXC];
  int exp_kind [MAXC];
  int exp_addr [MAXC];
  int exp_step [MAXC];
  int exp_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic build(input int n, input int src);
    int c, sc, a, kind;
    sc = (src > G - 1) ? G - 1 : src;
    for (int i = 0; i < MAXC; i++) begin
      exp_kind[i] = 0; exp_addr[i] = 0; exp_step[i] = 0;
    end
    c = 1;
    for (int s = 0; s < n; s++) begin
      for (int k = 0; k < 2 * G - 1; k++) begin
        if (k < G - 1)            begin kind = 1; a = k; end
        else if (k < 2 * G - 2)   begin kind = 2; a = k - (G - 1) + 1; end
        else                      begin kind = 3; a = sc; end
        while (!rdy[c] && c < MAXC - 4) begin
          exp_kind[c] = 4; exp_addr[c] = a; c++;
        end
        exp_kind[c] = kind; exp_addr[c] = a; exp_step[c] = s;
        c++;
      end
      c++;  // quiet cycle closing the step
    end
    exp_done = c;
  endtask

  task automatic run(input int n, input int src, input bit ign);
    logic [2:0] en, een;
    int last;
    build(n, src);
    last = (n == 0) ? 0 : n - 1;
    start_i = 1'b1; num_steps_i = SW'(n); src_idx_i = AW'(src); dp_ready_i = rdy[0];
    #2;
    chk("idle_busy", {31'b0, busy_o}, 0);
    @(posedge CLK); #1;
    start_i = 1'b0;
    for (int c = 1; c <= exp_done; c++) begin
      dp_ready_i = rdy[c];
      if (ign && c == 5) begin
        start_i = 1'b1; num_steps_i = SW'(n + 2);
      end else begin
        start_i = 1'b0; num_steps_i = SW'(n);
      end
      #2;
      en = {calc_Hy_en_o, calc_Ez_en_o, calc_src_en_o};
      case (exp_kind[c])
        1: een = 3'b100;
        2: een = 3'b010;
        3: een = 3'b001;
        default: een = 3'b000;
      endcase
      chk("onehot", {31'b0, $countones(en) <= 1}, 1);
      chk("enables", {29'b0, en}, {29'b0, een});
      if (exp_kind[c] != 0) chk("addr", {28'b0, cell_addr_o}, exp_addr[c]);
      if (exp_kind[c] >= 1 && exp_kind[c] <= 3) chk("step", {16'b0, step_cnt_o}, exp_step[c]);
      chk("busy", {31'b0, busy_o}, 1);
      chk("done", {31'b0, done_o}, (c == exp_done) ? 1 : 0);
      if (c == exp_done) chk("final_step", {16'b0, step_cnt_o}, last);
      @(posedge CLK); #1;
    end
    start_i = 1'b0; dp_ready_i = 1'b1;
    #2;
    chk("post_busy", {31'b0, busy_o}, 0);
    chk("post_done", {31'b0, done_o}, 0);
    chk("post_step", {16'b0, step_cnt_o}, last);
    @(posedge CLK); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {23'b0, busy_o, done_o, calc_Hy_en_o, calc_Ez_en_o, calc_src_en_o,
              cell_addr_o == '0, step_cnt_o == '0, 1'b0}, 32'h6);
  endtask

  initial begin
    RST = 1'b1; start_i = 1'b0; num_steps_i = '0; src_idx_i = '0; dp_ready_i = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk_all_zero("reset_state");
    RST = 1'b0;
    @(posedge CLK); #1;

    // Nominal run, full ready: done at cycle 1+2G*N = 49.
    for (int i = 0; i < MAXC; i++) rdy[i] = 1'b1;
    run(3, 5, 1'b0);
    chk("done_cycle_n3", exp_done, 49);

    // N=0: immediate done.
    run(0, 2, 1'b0);

    // Three-cycle stall while Ez sits at cell 4 (cycle 11 of step 0).
    rdy[11] = 1'b0; rdy[12] = 1'b0; rdy[13] = 1'b0;
    run(2, 3, 1'b0);
    chk("stall_addr_hold", exp_addr[12], 4);
    for (int i = 0; i < MAXC; i++) rdy[i] = 1'b1;

    // Clamped source plus a start pulse while busy.
    run(1, 12, 1'b1);

    // Reset mid-run aborts without done.
    start_i = 1'b1; num_steps_i = SW'(3); src_idx_i = AW'(5);
    @(posedge CLK); #1;
    start_i = 1'b0;
    repeat (19) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    chk_all_zero("mid_reset_1");
    @(posedge CLK); #1;
    chk_all_zero("mid_reset_2");
    RST = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #2;
      chk("no_done_after_rst", {30'b0, done_o, busy_o}, 0);
      @(posedge CLK); #1;
    end

    // Random ready and random N.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < MAXC; i++) rdy[i] = ($urandom_range(0, 3) != 0);
      run($urandom_range(0, 5), $urandom_range(0, 15), r[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
